// File: rtl/counter_pkg.sv
// Shared constants for the match counter array and its readout engine.
// COUNTER_READER_CHECKSUM_EN adds a trailing XOR-checksum beat to each sweep.
package counter_pkg;

  localparam int unsigned CTR_ADDR_W = 4;
  localparam int unsigned CTR_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
`ifdef COUNTER_READER_CHECKSUM_EN
    StChecksum,
`endif
    StPresent
  } reader_state_e;

endpackage

// File: rtl/counter_reader_if.sv
// Dump stream from the counter reader to the host/debug consumer.
interface counter_reader_if
  import counter_pkg::*;
#(
  parameter int unsigned ADDR_W = CTR_ADDR_W,
  parameter int unsigned DATA_W = CTR_DATA_W
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid, dump_addr, dump_data, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_addr, dump_data, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/counter_reader.sv
// Sweeps a wrapping range of counter addresses, reads each count and streams
// (addr, value) beats out over valid/ready.
// Optional: COUNTER_READER_CHECKSUM_EN appends an XOR-of-all-values beat.
module counter_reader
  import counter_pkg::*;
#(
  parameter int unsigned ADDR_W = CTR_ADDR_W,
  parameter int unsigned DATA_W = CTR_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] first_addr_in,
  input  logic [ADDR_W-1:0] last_addr_in,
  output logic              read_counter,
  output logic [ADDR_W-1:0] count_rd_addr_out,
  input  logic [DATA_W-1:0] count_in,
  counter_reader_if.master  dump,
  output logic              busy_out,
  output logic              done_out
);

  localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  reader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              beat_last_q, beat_last_d;
  logic              valid, done;
`ifdef COUNTER_READER_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q, xor_d;
`endif

  // Next-state, read-port and beat-register logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_addr_d = last_addr_q;
    lat_d       = lat_q;
    rd_d        = 1'b0;  // read_counter is a single-cycle strobe
    rd_addr_d   = rd_addr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    beat_last_d = beat_last_q;
    valid       = 1'b0;
    done        = 1'b0;
`ifdef COUNTER_READER_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          last_addr_d = last_addr_in;
          idx_d       = first_addr_in;
          rd_d        = 1'b1;
          rd_addr_d   = first_addr_in;
          state_d     = StIssue;
`ifdef COUNTER_READER_CHECKSUM_EN
          xor_d       = '0;
`endif
        end
      end
      StIssue: begin
        lat_d   = '0;
        state_d = StCapture;
      end
      StCapture: begin
        if (lat_q == LatW'(RD_LAT - 1)) begin
          addr_d      = idx_q;
          data_d      = count_in;
          beat_last_d = (idx_q == last_addr_q);
          state_d     = StPresent;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StPresent: begin
        valid = 1'b1;
        if (dump.dump_ready) begin
          if (beat_last_q) begin
`ifdef COUNTER_READER_CHECKSUM_EN
            xor_d   = xor_q ^ data_q;
            addr_d  = '0;
            data_d  = xor_q ^ data_q;
            state_d = StChecksum;
`else
            done    = 1'b1;
            state_d = StIdle;
`endif
          end else begin
`ifdef COUNTER_READER_CHECKSUM_EN
            xor_d     = xor_q ^ data_q;
`endif
            idx_d     = idx_q + 1'b1;
            rd_d      = 1'b1;
            rd_addr_d = idx_q + 1'b1;
            state_d   = StIssue;
          end
        end
      end
`ifdef COUNTER_READER_CHECKSUM_EN
      StChecksum: begin
        valid = 1'b1;
        if (dump.dump_ready) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_addr_q <= '0;
      lat_q       <= '0;
      rd_q        <= 1'b0;
      rd_addr_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      beat_last_q <= 1'b0;
`ifdef COUNTER_READER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_addr_q <= last_addr_d;
      lat_q       <= lat_d;
      rd_q        <= rd_d;
      rd_addr_q   <= rd_addr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      beat_last_q <= beat_last_d;
`ifdef COUNTER_READER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign read_counter      = rd_q;
  assign count_rd_addr_out = rd_addr_q;
  assign dump.dump_valid   = valid;
  assign dump.dump_addr    = addr_q;
  assign dump.dump_data    = data_q;
`ifdef COUNTER_READER_CHECKSUM_EN
  assign dump.dump_last    = (state_q == StChecksum);
`else
  assign dump.dump_last    = (state_q == StPresent) && beat_last_q;
`endif
  assign busy_out          = (state_q != StIdle);
  assign done_out          = done;

endmodule

// File: tb/tb_counter_reader.sv
// Self-checking bench for counter_reader: a beat-list model of each sweep is
// compared against the dump stream every cycle, plus directed literal checks.
module tb_counter_reader;
  import counter_pkg::*;

  localparam int unsigned AW = CTR_ADDR_W;
  localparam int unsigned DW = CTR_DATA_W;
`ifdef COUNTER_READER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_in = 1'b0;
  logic [AW-1:0] first_addr_in = '0;
  logic [AW-1:0] last_addr_in = '0;
  logic          read_counter;
  logic [AW-1:0] count_rd_addr_out;
  logic [DW-1:0] count_in = '0;
  logic          busy_out;
  logic          done_out;

  counter_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dump_if ();

  counter_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .start_in          (start_in),
    .first_addr_in     (first_addr_in),
    .last_addr_in      (last_addr_in),
    .read_counter      (read_counter),
    .count_rd_addr_out (count_rd_addr_out),
    .count_in          (count_in),
    .dump              (dump_if),
    .busy_out          (busy_out),
    .done_out          (done_out)
  );

  always #5 clk = ~clk;

  // Counter block model: one-cycle registered read.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (read_counter) count_in <= mem[count_rd_addr_out];

  int checks = 0, passed = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int done_cnt = 0, hs_cnt = 0, rc_cnt = 0, stall_cnt = 0;
  logic [AW-1:0] rc_last_addr = '0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Expected beat list for a sweep, from the range rules.
  function automatic int push_sweep(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int n = int'(AW'(l - f)) + 1;
    logic [DW-1:0] x = '0;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.a = AW'(f + k);
      b.d = mem[b.a];
      x   = x ^ b.d;
      b.l = (k == n - 1) && (EXTRA == 0);
      exp_q.push_back(b);
    end
`ifdef COUNTER_READER_CHECKSUM_EN
    begin
      beat_t c;
      c.a = '0;
      c.d = x;
      c.l = 1'b1;
      exp_q.push_back(c);
    end
`endif
    return n;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (read_counter) begin
        rc_cnt++;
        rc_last_addr = count_rd_addr_out;
      end
      check("rd_during_valid", 64'(read_counter && dump_if.dump_valid), 0);
      if (dump_if.dump_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("beat_addr", 64'(dump_if.dump_addr), 64'(exp_q[0].a));
          check("beat_data", 64'(dump_if.dump_data), 64'(exp_q[0].d));
          check("beat_last", 64'(dump_if.dump_last), 64'(exp_q[0].l));
          check("done_on_beat", 64'(done_out), 64'(dump_if.dump_ready && exp_q[0].l));
          if (!dump_if.dump_ready) stall_cnt++;
          else begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        check("last_without_valid", 64'(dump_if.dump_last), 0);
        check("done_without_valid", 64'(done_out), 0);
      end
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_sweep(input logic [AW-1:0] f, input logic [AW-1:0] l, output int n);
    @(posedge clk); #1;
    n = push_sweep(f, l);
    start_in = 1'b1;
    first_addr_in = f;
    last_addr_in = l;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_in = 1'b0;
    check("busy_after_start", 64'(busy_out), 1);
  endtask

  task automatic wait_done(input int base, input int budget);
    int i = 0;
    while (done_cnt == base && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("done_seen", 64'(done_cnt != base), 1);
    check("busy_after_done", 64'(busy_out), 0);
  endtask

  initial begin
    int n, d0, r0, h0, s0, i;
    for (int a = 0; a < 16; a++) mem[a] = 32'h100 + a;
    dump_if.dump_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_counter", 64'(read_counter), 0);
    check("rst_rd_addr", 64'(count_rd_addr_out), 0);
    check("rst_valid", 64'(dump_if.dump_valid), 0);
    check("rst_addr", 64'(dump_if.dump_addr), 0);
    check("rst_data", 64'(dump_if.dump_data), 0);
    check("rst_last", 64'(dump_if.dump_last), 0);
    check("rst_busy", 64'(busy_out), 0);
    check("rst_done", 64'(done_out), 0);
    reset = 1'b1;

    // Full range 0..15.
    d0 = done_cnt; r0 = rc_cnt;
    start_sweep(4'd0, 4'd15, n);
    check("model_full_count", 64'(n), 16);
    wait_done(d0, 200);
    check("full_done_cycles", 64'(done_cyc - start_cyc), 64'(48 + EXTRA));
    check("full_rd_strobes", 64'(rc_cnt - r0), 16);
    check("full_done_once", 64'(done_cnt - d0), 1);

    // Wrapping range 14..1.
    d0 = done_cnt;
    start_sweep(4'd14, 4'd1, n);
    check("model_wrap_count", 64'(n), 4);
    check("model_wrap_first", 64'({exp_q[0].a, exp_q[0].d}), 64'({4'd14, 32'h10E}));
    wait_done(d0, 100);
    check("wrap_done_cycles", 64'(done_cyc - start_cyc), 64'(12 + EXTRA));

    // Single beat 7..7.
    d0 = done_cnt; r0 = rc_cnt;
    start_sweep(4'd7, 4'd7, n);
    wait_done(d0, 50);
    check("single_rd_strobes", 64'(rc_cnt - r0), 1);
    check("single_rd_addr", 64'(rc_last_addr), 7);
    check("single_done_cycles", 64'(done_cyc - start_cyc), 64'(3 + EXTRA));

    // Backpressure on the fourth beat of 2..6.
    d0 = done_cnt; r0 = rc_cnt; h0 = hs_cnt; s0 = stall_cnt;
    start_sweep(4'd2, 4'd6, n);
    i = 0;
    while (hs_cnt - h0 < 3 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("stall_reach_beat3", 64'(hs_cnt - h0), 3);
    dump_if.dump_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    dump_if.dump_ready = 1'b1;
    wait_done(d0, 100);
    check("stall_cycles", 64'(stall_cnt - s0), 5);
    check("stall_rd_strobes", 64'(rc_cnt - r0), 5);
    check("stall_done_cycles", 64'(done_cyc - start_cyc), 64'(20 + EXTRA));

    // Start pulsed while busy is ignored.
    d0 = done_cnt; r0 = rc_cnt;
    start_sweep(4'd0, 4'd3, n);
    @(posedge clk); #1;
    start_in = 1'b1; first_addr_in = 4'd9; last_addr_in = 4'd9;
    @(posedge clk); #1;
    start_in = 1'b0;
    wait_done(d0, 100);
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_no_extra", 64'(exp_q.size()), 0);
    check("busy_start_rd_strobes", 64'(rc_cnt - r0), 4);
    check("busy_start_done_once", 64'(done_cnt - d0), 1);

    // Reset in PRESENT, then restart.
    dump_if.dump_ready = 1'b0;
    start_sweep(4'd0, 4'd15, n);
    i = 0;
    while (!dump_if.dump_valid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    check("reached_present", 64'(dump_if.dump_valid), 1);
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(dump_if.dump_valid), 0);
    check("async_rst_busy", 64'(busy_out), 0);
    check("async_rst_data", 64'(dump_if.dump_data), 0);
    check("async_rst_addr", 64'(dump_if.dump_addr), 0);
    check("async_rst_rd", 64'(read_counter), 0);
    check("async_rst_done", 64'(done_out), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    dump_if.dump_ready = 1'b1;
    check("no_done_on_reset", 64'(done_cnt - d0), 0);
    start_sweep(4'd3, 4'd3, n);
    wait_done(d0, 50);
    check("restart_done_cycles", 64'(done_cyc - start_cyc), 64'(3 + EXTRA));

`ifdef COUNTER_READER_CHECKSUM_EN
    // Checksum of 1,2,3 is zero.
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    d0 = done_cnt;
    start_sweep(4'd0, 4'd2, n);
    check("model_csum_beats", 64'(exp_q.size()), 4);
    check("model_csum_beat", 64'({exp_q[3].a, exp_q[3].d, exp_q[3].l}),
          64'({4'd0, 32'd0, 1'b1}));
    wait_done(d0, 50);
    check("csum_done_cycles", 64'(done_cyc - start_cyc), 10);
`endif

    repeat (5) @(posedge clk);
    check("model_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
